// File: rtl/pid_pkg.sv
// Shared constants and the Q8.8 data type for the PID controller.
package pid_pkg;

   localparam int DATA_W    = 16;
   localparam int FRAC_BITS = 8;
   localparam int ACC_W     = 20;
   localparam int INT_LIMIT = 32767;

   // Signed Q8.8 value: 8 integer bits (incl. sign), 8 fractional bits.
   typedef logic signed [DATA_W-1:0] q8_8_t;

endpackage

// File: rtl/pid_sat.sv
// Generic signed saturator: clamps a wide signed input into [MIN_V, MAX_V]
// and returns it at a narrower width. The limits must be representable in OUT_W.
module pid_sat #(
   parameter int     IN_W  = 40,
   parameter int     OUT_W = 16,
   parameter longint MAX_V = 64'sd32767,
   parameter longint MIN_V = -64'sd32768
) (
   input  logic signed [IN_W-1:0]  din,
   output logic signed [OUT_W-1:0] dout
);

   localparam logic signed [IN_W-1:0] HI_C = IN_W'(MAX_V);
   localparam logic signed [IN_W-1:0] LO_C = IN_W'(MIN_V);

   // Compare against both limits at full width, then narrow the result.
   always_comb begin
      if (din > HI_C) begin
         dout = HI_C[OUT_W-1:0];
      end else if (din < LO_C) begin
         dout = LO_C[OUT_W-1:0];
      end else begin
         dout = din[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/pid_controller.sv
// Two-stage fixed-point PID controller.
// Stage 1 registers the error, the previous error and the clamped integral.
// Stage 2 forms P, I and D from those registers and saturates the sum.
module pid_controller
   import pid_pkg::q8_8_t;
   import pid_pkg::ACC_W;
#(
   parameter int FRAC_BITS = pid_pkg::FRAC_BITS,
   parameter int INT_LIMIT = pid_pkg::INT_LIMIT
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  enable,
   input  q8_8_t setpoint,
   input  q8_8_t feedback,
   input  q8_8_t kp,
   input  q8_8_t ki,
   input  q8_8_t kd,
   output q8_8_t pid_out
);

   localparam int ERR_W  = 17;
   localparam int PROD_W = 40;

   // Stage 1 state
   logic signed [ERR_W-1:0] error_q, error_d;
   logic signed [ERR_W-1:0] prev_error_q, prev_error_d;
   logic signed [ACC_W-1:0] integral_acc, integral_d;
   // Stage 2 state
   q8_8_t                   pid_out_q, pid_out_d;

   // Combinational datapath
   logic signed [ERR_W-1:0]  err_s;
   logic signed [ACC_W:0]    int_sum_s;
   logic signed [ACC_W-1:0]  int_clamp_s;
   logic signed [ERR_W:0]    err_diff_s;
   logic signed [PROD_W-1:0] p_term_s, i_term_s, d_term_s, sum_s;
   q8_8_t                    out_sat_s;

   // A 17-bit difference of two 16-bit values cannot overflow.
   assign err_s      = ERR_W'(setpoint) - ERR_W'(feedback);
   // One extra bit so the accumulator update never wraps before clamping.
   assign int_sum_s  = (ACC_W+1)'(integral_acc) + (ACC_W+1)'(err_s);
   assign err_diff_s = (ERR_W+1)'(error_q) - (ERR_W+1)'(prev_error_q);

   // Operands are sign-extended to 40 bits, so products and their sum are exact.
   assign p_term_s = (PROD_W'(kp) * PROD_W'(error_q))      >>> FRAC_BITS;
   assign i_term_s = (PROD_W'(ki) * PROD_W'(integral_acc)) >>> FRAC_BITS;
   assign d_term_s = (PROD_W'(kd) * PROD_W'(err_diff_s))   >>> FRAC_BITS;
   assign sum_s    = p_term_s + i_term_s + d_term_s;

   // Anti-windup clamp of the integral accumulator.
   pid_sat #(
      .IN_W  (ACC_W + 1),
      .OUT_W (ACC_W),
      .MAX_V (longint'(INT_LIMIT)),
      .MIN_V (-longint'(INT_LIMIT))
   ) u_int_sat (
      .din  (int_sum_s),
      .dout (int_clamp_s)
   );

   // Output saturation to the Q8.8 range.
   pid_sat #(
      .IN_W  (PROD_W),
      .OUT_W (16),
      .MAX_V (64'sd32767),
      .MIN_V (-64'sd32768)
   ) u_out_sat (
      .din  (sum_s),
      .dout (out_sat_s)
   );

   // Next-state selection: run the loop when enabled, otherwise clear everything.
   always_comb begin
      error_d      = '0;
      prev_error_d = '0;
      integral_d   = '0;
      pid_out_d    = '0;
      if (enable) begin
         error_d      = err_s;
         prev_error_d = error_q;
         integral_d   = int_clamp_s;
         pid_out_d    = out_sat_s;
      end else begin
         error_d      = '0;
         prev_error_d = '0;
         integral_d   = '0;
         pid_out_d    = '0;
      end
   end

   // Stage 1 registers: error history and integral accumulator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         error_q      <= '0;
         prev_error_q <= '0;
         integral_acc <= '0;
      end else begin
         error_q      <= error_d;
         prev_error_q <= prev_error_d;
         integral_acc <= integral_d;
      end
   end

   // Stage 2 register: saturated control output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pid_out_q <= '0;
      end else begin
         pid_out_q <= pid_out_d;
      end
   end

   assign pid_out = pid_out_q;

endmodule

// File: tb/tb_pid_controller.sv
// Self-checking bench for pid_controller: directed vector table, hand-written
// windup and reset sequences, then random stimulus against a reference model.
module tb_pid_controller;

   logic               clk;
   logic               rst_n;
   logic               en;
   logic signed [15:0] sp, fb, kp, ki, kd;
   logic signed [15:0] pid_out;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state (plain integers)
   longint m_err, m_prev, m_acc, m_out;

   typedef struct {
      logic        en;
      logic [15:0] sp, fb, kp, ki, kd;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[$];

   pid_controller dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (en),
      .setpoint (sp),
      .feedback (fb),
      .kp       (kp),
      .ki       (ki),
      .kd       (kd),
      .pid_out  (pid_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic longint clampl(longint v, longint lo, longint hi);
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   function automatic vec_t mk(logic e, logic [15:0] s, logic [15:0] f, logic [15:0] p,
                               logic [15:0] i, logic [15:0] d, logic [15:0] x);
      vec_t v;
      v.en = e; v.sp = s; v.fb = f; v.kp = p; v.ki = i; v.kd = d; v.exp = x;
      return v;
   endfunction

   task automatic model_clear();
      m_err = 0; m_prev = 0; m_acc = 0; m_out = 0;
   endtask

   // One rising edge of the controller, from the textual rules.
   task automatic model_edge();
      longint e_new, p, i, d;
      if (!en) begin
         model_clear();
      end else begin
         e_new = longint'(sp) - longint'(fb);
         p = (longint'(kp) * m_err) >>> 8;
         i = (longint'(ki) * m_acc) >>> 8;
         d = (longint'(kd) * (m_err - m_prev)) >>> 8;
         m_out  = clampl(p + i + d, -32768, 32767);
         m_acc  = clampl(m_acc + e_new, -32767, 32767);
         m_prev = m_err;
         m_err  = e_new;
      end
   endtask

   task automatic check(string name, logic [15:0] act, logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic set_in(logic e, logic [15:0] s, logic [15:0] f,
                         logic [15:0] p, logic [15:0] i, logic [15:0] d);
      en = e; sp = s; fb = f; kp = p; ki = i; kd = d;
   endtask

   initial begin
      rst_n = 1'b0;
      set_in(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      check("reset", pid_out, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;

      // P-only
      vecs.push_back(mk(1'b1, 16'h0500, 16'h0000, 16'h0200, 16'h0000, 16'h0000, 16'h0000));
      vecs.push_back(mk(1'b1, 16'h0500, 16'h0000, 16'h0200, 16'h0000, 16'h0000, 16'h0A00));
      vecs.push_back(mk(1'b1, 16'h0500, 16'h0000, 16'h0200, 16'h0000, 16'h0000, 16'h0A00));
      vecs.push_back(mk(1'b0, 16'h0500, 16'h0000, 16'h0200, 16'h0000, 16'h0000, 16'h0000));
      // I-only (also shows the integral was cleared by the disable above)
      vecs.push_back(mk(1'b1, 16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0000));
      vecs.push_back(mk(1'b1, 16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0100));
      vecs.push_back(mk(1'b1, 16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0200));
      vecs.push_back(mk(1'b1, 16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0300));
      vecs.push_back(mk(1'b0, 16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0000));
      // D-only: one-cycle pulse on an error step
      vecs.push_back(mk(1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000));
      vecs.push_back(mk(1'b1, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000));
      vecs.push_back(mk(1'b1, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0100));
      vecs.push_back(mk(1'b1, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000));
      vecs.push_back(mk(1'b0, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000));
      // Saturation both ways
      vecs.push_back(mk(1'b1, 16'h6400, 16'h9C00, 16'h7F00, 16'h0000, 16'h0000, 16'h0000));
      vecs.push_back(mk(1'b1, 16'h6400, 16'h9C00, 16'h7F00, 16'h0000, 16'h0000, 16'h7FFF));
      vecs.push_back(mk(1'b1, 16'h9C00, 16'h6400, 16'h7F00, 16'h0000, 16'h0000, 16'h7FFF));
      vecs.push_back(mk(1'b1, 16'h9C00, 16'h6400, 16'h7F00, 16'h0000, 16'h0000, 16'h8000));

      foreach (vecs[k]) begin
         set_in(vecs[k].en, vecs[k].sp, vecs[k].fb, vecs[k].kp, vecs[k].ki, vecs[k].kd);
         step();
         check($sformatf("vec%0d", k), pid_out, vecs[k].exp);
      end

      // Asynchronous reset mid-run while the output sits at 0x8000
      rst_n = 1'b0;
      #1;
      check("rst_async", pid_out, 16'h0000);
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;

      // Windup then unwind
      set_in(1'b1, 16'h0A00, 16'h0000, 16'h0080, 16'h0080, 16'h0000);
      for (int c = 0; c < 20; c++) begin
         step();
         check($sformatf("windup%0d", c), pid_out, 16'(m_out));
      end
      check("windup_clamped", pid_out, 16'h44FF);
      sp = 16'hF600;
      for (int c = 0; c < 12; c++) begin
         step();
         check($sformatf("unwind%0d", c), pid_out, 16'(m_out));
      end
      en = 1'b0;
      step();
      check("disable", pid_out, 16'h0000);

      // Random stimulus against the model, including gain changes and idle cycles
      for (int c = 0; c < 400; c++) begin
         en = ($urandom_range(0, 15) != 0);
         if (c % 8 == 0) begin
            kp = 16'($urandom);
            ki = 16'($urandom_range(0, 16'h03FF)) - 16'h0200;
            kd = 16'($urandom);
         end
         sp = 16'($urandom);
         fb = (c % 3 == 0) ? 16'($urandom) : sp - 16'($urandom_range(0, 16'h0400));
         step();
         check($sformatf("rand%0d", c), pid_out, 16'(m_out));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
